// File: rtl/regfile_writeback_sink.sv
// -----------------------------------------------------------------------------
// regfile_writeback_sink
//
// RV32E integer register file (x0..x15) on the writeback side of the pipeline.
// It takes the single WB-stage write and serves two combinational decode reads.
// It also tracks registers that still wait for a multi-cycle producer (loads),
// so decode can stall on operands that are not available yet.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous reset, active high
//   rd_WB          writeback destination register
//   wd_WB          writeback data
//   regfile_we_WB  writeback write enable
//   rs1_addr       decode read port 1 address
//   rs2_addr       decode read port 2 address
//   rs1_used       decode instruction reads rs1
//   rs2_used       decode instruction reads rs2
//   claim_valid    decode issues a multi-cycle producer this cycle
//   claim_rd       destination of that producer
//   rs1_data       read port 1 data (write-to-read bypassed)
//   rs2_data       read port 2 data (write-to-read bypassed)
//   busy_rs1       rs1 still waits for its producer
//   busy_rs2       rs2 still waits for its producer
//   hazard_stall   decode must hold this cycle
// -----------------------------------------------------------------------------
module regfile_writeback_sink #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      rd_WB,
    input  logic [XLEN-1:0] wd_WB,
    input  logic            regfile_we_WB,
    input  logic [3:0]      rs1_addr,
    input  logic [3:0]      rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            claim_valid,
    input  logic [3:0]      claim_rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            hazard_stall
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic wb_write;      // architecturally visible write (x0 excluded)
    logic claim_accept;  // claim that actually reaches the scoreboard
    logic wb_hits_rs1;
    logic wb_hits_rs2;

    assign wb_write     = regfile_we_WB && (rd_WB != 4'd0);
    assign claim_accept = claim_valid && !hazard_stall && (claim_rd != 4'd0);

    // A write landing this cycle already carries the operand, so it hides
    // the busy bit and feeds the read port directly.
    assign wb_hits_rs1 = wb_write && (rd_WB == rs1_addr);
    assign wb_hits_rs2 = wb_write && (rd_WB == rs2_addr);

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // NOTE: the array sits in the reset branch because reads must return 0
    // right after reset; this rules out a RAM macro and keeps it in flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values.
            regs[rd_WB] <= wd_WB;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 is hardwired, otherwise bypass or array
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: each output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wb_hits_rs1) begin
            rs1_data = wd_WB;
        end
        if (wb_hits_rs2) begin
            rs2_data = wd_WB;
        end
        if (rs1_addr == 4'd0) begin
            rs1_data = '0;
        end
        if (rs2_addr == 4'd0) begin
            rs2_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    // Clear is applied before set so that a new claim on the register being
    // written back wins: the new producer is the one still outstanding.
    always_comb begin
        busy_next = busy;
        if (wb_write) begin
            busy_next[rd_WB] = 1'b0;
        end
        if (claim_accept) begin
            busy_next[claim_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Hazard outputs (combinational; reset clears busy immediately)
    // ------------------------------------------------------------------
    assign busy_rs1     = busy[rs1_addr] && !wb_hits_rs1;
    assign busy_rs2     = busy[rs2_addr] && !wb_hits_rs2;
    assign hazard_stall = (rs1_used && busy_rs1) || (rs2_used && busy_rs2);

endmodule

// File: doc/regfile_writeback_sink.md
Name: regfile_writeback_sink

Overview:
- Writeback-side consumer of the MEMEX/WB pipeline register: the RV32E integer register file (x0..x15) that accepts the WB-stage write and serves decode-stage reads.
- Adds same-cycle write-to-read bypass and a per-register pending-write scoreboard, so decode stalls on operands still in flight from multi-cycle producers (loads).
- Sits between pipeline_register_MEMEX_WB (write side) and the decode stage (read side).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 16, architectural register count (RV32E); address width is fixed at 4

Ports:
clk  in  1  core clock, rising-edge
rst  in  1  asynchronous reset, active-high
rd_WB  in  4  writeback destination register
wd_WB  in  XLEN  writeback data (the alu_result_WB value)
regfile_we_WB  in  1  writeback write enable
rs1_addr  in  4  decode read port 1 address
rs2_addr  in  4  decode read port 2 address
rs1_used  in  1  decode instruction actually reads rs1
rs2_used  in  1  decode instruction actually reads rs2
claim_valid  in  1  decode issues a multi-cycle producer this cycle
claim_rd  in  4  destination of the claimed producer
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
busy_rs1  out  1  rs1 has an outstanding claim
busy_rs2  out  1  rs2 has an outstanding claim
hazard_stall  out  1  decode must hold this cycle

Behaviour:
- Reset (async, rst=1): all registers x1..x15 clear to 0; all busy bits clear to 0. Outputs therefore read 0, and busy_rs1/busy_rs2/hazard_stall are 0 while rst is held.
- x0: always reads 0; writes to rd_WB=0 are ignored; a claim with claim_rd=0 is ignored; busy[0] is constant 0.
- Write: on rising clk, if regfile_we_WB and rd_WB!=0, then reg[rd_WB] <= wd_WB. One-cycle write latency.
- Read: combinational. If regfile_we_WB and rd_WB==rsN_addr and rsN_addr!=0, rsN_data = wd_WB (bypass); otherwise rsN_data = reg[rsN_addr]. The bypass applies to both ports independently; when rs1_addr==rs2_addr, both ports are bypassed.
- Scoreboard: a 16-entry busy bit vector, updated on rising clk.
  - Set: claim_valid and !hazard_stall and claim_rd!=0 -> busy[claim_rd] <= 1.
  - Clear: regfile_we_WB and rd_WB!=0 -> busy[rd_WB] <= 0.
  - Simultaneous set and clear of the same index: set wins (the new producer is outstanding).
  - Claims while hazard_stall=1 are dropped. Decode re-presents the claim after the stall lifts.
- Busy outputs: busy_rsN = busy[rsN_addr] & !(regfile_we_WB & rd_WB==rsN_addr). A write in the same cycle resolves the hazard, and the bypassed data is valid.
- hazard_stall = (rs1_used & busy_rs1) | (rs2_used & busy_rs2). Purely combinational; no registered latency.
- A write to a non-busy register is legal (ALU result path) and leaves busy at 0.
- A write to a busy register always clears it. Only one outstanding producer per rd is supported; decode guarantees this ordering.
- Reset mid-operation: all pending claims are discarded immediately. The first post-reset cycle sees no stall.
- Data and register width are XLEN. No sign or width conversion is performed.

Test Plan:
- Reset then read all: assert rst, write x5=0xDEADBEEF before reset -> after reset rs1_addr=5 reads 0x00000000; busy_rs1=0; hazard_stall=0.
- Write/read-back plus x0: we=1, rd=3, wd=0x12345678 for one cycle, then rs2_addr=3 -> 0x12345678. Write rd=0, wd=0xFFFFFFFF -> rs1_addr=0 reads 0.
- Same-cycle bypass: we=1, rd=7, wd=0xA5A5A5A5 with rs1_addr=rs2_addr=7 in the same cycle -> both ports read 0xA5A5A5A5 before the clock edge.
- Load-use stall: claim rd=4; next cycle rs1_addr=4, rs1_used=1 -> hazard_stall=1, busy_rs1=1. In the WB write cycle (rd=4, wd=0x55) -> hazard_stall=0, rs1_data=0x55. The cycle after -> busy clear.
- Set/clear collision: busy[6]=1; same cycle write rd=6 and claim rd=6 -> next cycle busy_rs1 (rs1_addr=6)=1.
- Claim gating and async reset: hazard_stall=1 with claim rd=9 -> busy[9] stays 0. Set busy[2] and pulse rst between clock edges -> busy_rs1 (rs1_addr=2) drops to 0 without waiting for a clock edge.
